fir_sample_streamer: RTL and testbench

Transmit-side sample source for the fir filter's xin input. Software or a bench loader fills a sample FIFO. On start, the block streams a programmed number of samples at a programmable rate with a valid strobe. It then appends zero samples to drain the filter's delay line and pulses done, so a downstream compare/capture stage knows the run has ended.

---
 rtl/fir_sample_streamer.sv | 132 +++++++++++++
 tb/tb_fir_sample_streamer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fir_sample_streamer.sv
// fir_sample_streamer: FIFO-fed paced sample source for the fir xin input, with zero flush and done pulse.
// Optional FIR_STREAMER_REPLAY_EN turns the FIFO into a circular pattern buffer during a run.
module fir_sample_streamer #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 16,
  parameter int DIV_W     = 8,
  parameter int CNT_W     = 16,
  parameter int FLUSH_LEN = 10
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  input  logic                       start,
  input  logic                       abort,
  input  logic [DIV_W-1:0]           rate_div,
  input  logic [CNT_W-1:0]           num_samples,
  output logic [DATA_W-1:0]          xin,
  output logic                       xin_valid,
  output logic                       busy,
  output logic                       underrun,
  output logic                       done
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = $clog2(FLUSH_LEN + 2);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t            state, state_n;
  logic [DIV_W-1:0]  rate, rate_n, tcnt, tcnt_n;
  logic [CNT_W-1:0]  rem, rem_n;
  logic [FW-1:0]     fcnt, fcnt_n;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rp, wp;
  logic [DATA_W-1:0] head, xin_n, wdata;
  logic [LW-1:0]     level_n;
  logic              xv_n, und_n, done_n, busy_n, pop, wr, tick, empty;
  assign head   = mem[rp];
  assign empty  = level == '0;
  assign tick   = state != IDLE && tcnt == '0;
  assign busy_n = state_n != IDLE;
`ifdef FIR_STREAMER_REPLAY_EN
  // popped head is re-pushed at the tail, so a run never changes the occupancy
  assign wr      = pop || (wr_en && state == IDLE && !full);
  assign wdata   = pop ? head : wr_data;
  assign level_n = level + LW'(wr && !pop);
`else
  assign wr      = wr_en && (!full || pop);
  assign wdata   = wr_data;
  assign level_n = level + LW'(wr) - LW'(pop);
`endif
  always_comb begin
    state_n = state;
    rate_n  = rate;
    tcnt_n  = (tcnt == rate) ? '0 : tcnt + 1'b1;
    rem_n   = rem;
    fcnt_n  = fcnt;
    xin_n   = xin;
    xv_n    = 1'b0;
    und_n   = underrun;
    done_n  = 1'b0;
    pop     = 1'b0;
    if (state == IDLE) begin
      tcnt_n = '0;
      if (start && num_samples != '0) begin
        state_n = RUN;
        rate_n  = rate_div;
        rem_n   = num_samples;
        und_n   = 1'b0;
      end else done_n = start;
    end else if (abort) begin
      state_n = IDLE;
      tcnt_n  = '0;
    end else if (tick) begin
      if (state == RUN) begin
        pop    = !empty;
        xin_n  = empty ? '0 : head;
        xv_n   = 1'b1;
        und_n  = underrun | empty;
        rem_n  = rem - 1'b1;
        fcnt_n = FW'(FLUSH_LEN);
        if (rem == CNT_W'(1)) state_n = (FLUSH_LEN == 0) ? DONE : FLUSH;
      end else if (state == FLUSH) begin
        xin_n  = '0;
        xv_n   = 1'b1;
        fcnt_n = fcnt - 1'b1;
        if (fcnt == FW'(1)) state_n = DONE;
      end else begin
        // done waits one full tick period after the last flush sample
        done_n  = 1'b1;
        state_n = IDLE;
      end
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rate      <= '0;
      tcnt      <= '0;
      rem       <= '0;
      fcnt      <= '0;
      rp        <= '0;
      wp        <= '0;
      level     <= '0;
      full      <= 1'b0;
      xin       <= '0;
      xin_valid <= 1'b0;
      busy      <= 1'b0;
      underrun  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      rate      <= rate_n;
      tcnt      <= tcnt_n;
      rem       <= rem_n;
      fcnt      <= fcnt_n;
      rp        <= rp + AW'(pop);
      wp        <= wp + AW'(wr);
      level     <= level_n;
      full      <= level_n == LW'(DEPTH);
      xin       <= xin_n;
      xin_valid <= xv_n;
      busy      <= busy_n;
      underrun  <= und_n;
      done      <= done_n;
    end
  end
  always_ff @(posedge clock) begin
    if (wr) mem[wp] <= wdata;
  end
endmodule

// File: tb/tb_fir_sample_streamer.sv
// tb_fir_sample_streamer: directed + random runs of fir_sample_streamer against a queue-based reference model.
module tb_fir_sample_streamer;
  localparam int DEPTH = 16;
  localparam int FL    = 10;
  logic        clock = 1'b0, reset = 1'b0, wr_en = 1'b0, start = 1'b0, abort = 1'b0;
  logic [15:0] wr_data = '0, num_samples = '0;
  logic [7:0]  rate_div = '0;
  logic        full, xin_valid, busy, underrun, done;
  logic [4:0]  level;
  logic [15:0] xin;
  int          n_assert = 0, n_fail = 0;
  logic [15:0] q[$];
  logic [15:0] exp_xin = '0;
  logic        exp_und = 1'b0;

  always #5 clock = ~clock;

  fir_sample_streamer dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full), .level(level),
    .start(start), .abort(abort), .rate_div(rate_div), .num_samples(num_samples), .xin(xin),
    .xin_valid(xin_valid), .busy(busy), .underrun(underrun), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic load(input logic [15:0] v);
    @(negedge clock);
    wr_en = 1'b1; wr_data = v;
    @(negedge clock);
    wr_en = 1'b0;
    if (q.size() < DEPTH) q.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1'b0;
    @(negedge clock); reset = 1'b1;
    q.delete(); exp_xin = '0; exp_und = 1'b0;
  endtask

  // Sample i of a run (payload then flush zeros) appears i*(rate+1)+1 cycles after start;
  // done follows one period after the last one. The queue models FIFO contents.
  task automatic run(input int rate, input int n, input int abort_k, input int wr_k, input logic [15:0] wv);
    int period, total, done_k, idx;
    bit wr_p, ab_p, popped;
    logic [15:0] pv;
    period = rate + 1; total = n + FL;
    done_k = (n == 0) ? 0 : 1 + total * period;
    wr_p = 0; ab_p = 0;
    @(negedge clock);
    rate_div = 8'(rate); num_samples = 16'(n); start = 1'b1;
    if (n != 0) exp_und = 1'b0;
    for (int k = 0; k <= done_k + 1; k++) begin
      @(negedge clock);
      start = 1'b0; wr_en = 1'b0; abort = 1'b0;
      if (ab_p) begin
        chk("abort_valid", xin_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_xin", xin, exp_xin);
        chk("abort_level", level, q.size());
        break;
      end
      popped = 0;
      idx = (k >= 1) ? (k - 1) / period : 0;
      if (n != 0 && k >= 1 && (k - 1) % period == 0 && idx < total) begin
        if (idx < n) begin
          if (q.size() != 0) begin
            pv = q.pop_front(); popped = 1; exp_xin = pv;
`ifdef FIR_STREAMER_REPLAY_EN
            q.push_back(pv);
`endif
          end else begin
            exp_xin = '0; exp_und = 1'b1;
          end
        end else exp_xin = '0;
        chk("valid_hi", xin_valid, 1);
        chk("xin", xin, exp_xin);
      end else begin
        chk("valid_lo", xin_valid, 0);
        chk("xin_hold", xin, exp_xin);
      end
      if (wr_p) begin
`ifdef FIR_STREAMER_REPLAY_EN
        if (k - 1 >= done_k && q.size() < DEPTH) q.push_back(wv);
`else
        if (q.size() + (popped ? 1 : 0) < DEPTH || popped) q.push_back(wv);
`endif
        wr_p = 0;
      end
      chk("done", done, k == done_k);
      chk("busy", busy, n != 0 && k < done_k);
      chk("level", level, q.size());
      chk("full", full, q.size() == DEPTH);
      if (k == wr_k) begin wr_en = 1'b1; wr_data = wv; wr_p = 1; end
      if (k == abort_k) begin abort = 1'b1; ab_p = 1; end
    end
    chk("underrun", underrun, exp_und);
  endtask

  initial begin
    int r, n;
    @(negedge clock);
    chk("rst_level", level, 0);
    chk("rst_full", full, 0);
    chk("rst_xin", xin, 0);
    chk("rst_valid", xin_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_done", done, 0);
    reset = 1'b1;
    // basic 4-sample run at full rate
    for (int i = 1; i <= 4; i++) load(16'(i));
    run(0, 4, -1, -1, '0);
    // paced run
    do_reset();
    for (int i = 0; i < 5; i++) load(16'($urandom_range(1, 65535)));
    run(3, 5, -1, -1, '0);
    // underrun: fewer samples than requested
    do_reset();
    for (int i = 0; i < 2; i++) load(16'($urandom_range(1, 65535)));
    run(0, 4, -1, -1, '0);
    repeat (3) @(negedge clock);
    chk("underrun_sticky", underrun, 1);
    run(0, 0, -1, -1, '0);
    // full FIFO, dropped write, push on a pop cycle
    do_reset();
    for (int i = 0; i < DEPTH; i++) load(16'($urandom_range(1, 65535)));
    chk("fill_full", full, 1);
    chk("fill_level", level, DEPTH);
    load(16'hdead);
    chk("drop_level", level, DEPTH);
    chk("drop_full", full, 1);
    run(0, 4, -1, 0, 16'hbeef);
    // random rate and length
    do_reset();
    r = $urandom_range(0, 2); n = $urandom_range(1, 6);
    for (int i = 0; i < n; i++) load(16'($urandom_range(1, 65535)));
    run(r, n, -1, -1, '0);
    // abort after three valids, then drain what is left
    do_reset();
    for (int i = 0; i < 8; i++) load(16'($urandom_range(1, 65535)));
    run(1, 8, 5, -1, '0);
    chk("abort_level_after", level, q.size());
    run(0, 5, -1, -1, '0);
    // asynchronous reset in the middle of a run
    for (int i = 0; i < 3; i++) load(16'($urandom_range(1, 65535)));
    @(negedge clock); rate_div = 8'd2; num_samples = 16'd3; start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_full", full, 0);
    chk("arst_xin", xin, 0);
    chk("arst_valid", xin_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_underrun", underrun, 0);
    chk("arst_done", done, 0);
    q.delete(); exp_xin = '0; exp_und = 1'b0;
    @(negedge clock); reset = 1'b1;
    run(0, 1, -1, -1, '0);
`ifdef FIR_STREAMER_REPLAY_EN
    do_reset();
    load(16'd3); load(16'd7); load(16'd9);
    run(0, 7, -1, -1, '0);
    chk("replay_level", level, 3);
    run(0, 1, -1, -1, '0);
    chk("replay_head", xin, 7);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
